// File: rtl/seg_pkg.sv
// seg_pkg: shared segment glyphs and FSM state encoding for the scan driver
package seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [15:0][6:0] GLYPH = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one input bit per cycle
module bin2bcd_seq #(
  parameter int WIDTH = 8,
  localparam int CD = (WIDTH + 2) / 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [WIDTH-1:0] bin,
  output logic            busy,
  output logic [4*CD-1:0] bcd,
  output logic            valid
);
  import seg_pkg::*;
  localparam int BW = 4 * CD;
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  // add-3 correction on every nibble, then shift in the next MSB; valid flags the final shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < CD; i++)
      adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    valid = busy_q && cnt_q == CW'(WIDTH - 1);
    sr_d = sr_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    if (start && !busy_q) begin
      sr_d = bin;
      bcd_d = '0;
      cnt_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {adj[BW-2:0], sr_q[WIDTH-1]};
      sr_d = sr_q << 1;
      cnt_d = cnt_q + 1'b1;
      busy_d = !valid;
    end
  end
  // conversion state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  assign busy = busy_q;
  assign bcd = bcd_q;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: handshake-loaded BCD/hex value scanned onto a multiplexed 7-segment display
module seg_scan_driver #(
  parameter int WIDTH = 8,
  parameter int DIGITS = 3,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  bin,
  input  logic              hex_mode,
  input  logic              bin_valid,
  output logic              bin_ready,
  output logic              done,
  output logic              ovf,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);
  import seg_pkg::*;
  localparam int CD = (WIDTH + 2) / 3;
  localparam int BW = 4 * CD;
  localparam int DW = 4 * DIGITS;
  localparam int EW = BW > DW ? BW : DW;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int RW = $clog2(REFRESH_DIV);
  state_t state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic hex_q, hex_d;
  logic [DW-1:0] disp_q, disp_d;
  logic ovf_q, ovf_d, done_q, done_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d, nz;
  logic [6:0] seg_q, seg_d;
  logic [BW-1:0] bcd;
  logic [EW-1:0] bin_x, bcd_x;
  logic [DW-1:0] cur;
  logic accept, conv_busy, conv_valid, wrap, blank;
  assign accept = bin_valid && state_q == IDLE && !conv_busy;
  assign bin_x = EW'(bin_q);
  assign bcd_x = EW'(bcd);
  bin2bcd_seq #(.WIDTH(WIDTH)) u_conv (
    .clk(clk),
    .rst_n(rst_n),
    .start(accept && !hex_mode),
    .bin(bin),
    .busy(conv_busy),
    .bcd(bcd),
    .valid(conv_valid)
  );
  // handshake FSM; the display register only changes in COMMIT so the old value stays up meanwhile
  always_comb begin
    state_d = state_q;
    bin_d = bin_q;
    hex_d = hex_q;
    disp_d = disp_q;
    ovf_d = ovf_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        bin_d = bin;
        hex_d = hex_mode;
        state_d = hex_mode ? COMMIT : SHIFT;
      end
      SHIFT: state_d = conv_valid ? COMMIT : SHIFT;
      COMMIT: begin
        disp_d = hex_q ? bin_x[DW-1:0] : bcd_x[DW-1:0];
        ovf_d = hex_q ? |(bin_x >> DW) : |(bcd_x >> DW);
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // handshake and display registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q <= '0;
      hex_q <= 1'b0;
      disp_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      hex_q <= hex_d;
      disp_q <= disp_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  // refresh counter, digit select and glyph lookup with leading-zero blanking
  always_comb begin
    for (int i = 0; i < DIGITS; i++) nz[i] = |disp_q[4*i+:4];
    wrap = ref_q == RW'(REFRESH_DIV - 1);
    ref_d = wrap ? '0 : ref_q + 1'b1;
    idx_d = !wrap ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
    cur = disp_q >> (4 * idx_q);
    blank = BLANK_LZ != 0 && idx_q != '0 && (nz >> idx_q) == '0;
    an_d = ~(DIGITS'(1) << idx_q);
    seg_d = ovf_q ? SEG_DASH : blank ? SEG_BLANK : GLYPH[cur[3:0]];
  end
  // scan registers; an/seg are registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ref_q <= '0;
      idx_q <= '0;
      an_q <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  assign bin_ready = state_q == IDLE;
  assign done = done_q;
  assign ovf = ovf_q;
  assign an = an_q;
  assign seg = seg_q;
endmodule
